phase_readout: RTL and testbench
================================

// Module: phase_readout
// PURPOSE
//  Run controller and result unloader directly downstream of the phase sampler.
//  - On start, pulses the sampler's counter reset, then lets the sampler
//    integrate for run_cycles clocks.
//  - Snapshots the N-bit phase vector and streams it out as WORD-bit words
//    over a valid/ready handshake to the host interface.
// PARAMETERS
//  N     3   number of spins; width of phase input
//  WORD  32  output word width; NWORDS = ceil(N/WORD), localparam
// PORTS
//  clk          in   1     single clock (sampler shares it)
//  rst          in   1     asynchronous, active-high reset
//  start        in   1     begin a run; sampled in IDLE only
//  run_cycles   in   32    integration length in clk cycles; latched on accepted start
//  phase        in   N     sampler output; 1 = in phase with local field
//  sample_rstn  out  1     active-low reset to sampler counters (registered)
//  busy         out  1     high in every state except IDLE
//  out_data     out  WORD  snapshot word; bits above N zero-padded
//  out_valid    out  1     out_data is valid
//  out_ready    in   1     consumer accepts when out_valid & out_ready
//  out_last     out  1     current word is word NWORDS-1
//  done         out  1     one-cycle pulse after the final word transfers
// BEHAVIOUR
//  - Reset (async assert): state=IDLE, sample_rstn=0, busy=0, out_valid=0,
//    out_last=0, done=0, out_data=0, snapshot=0, timer=0, word index=0.
//  - FSM states: IDLE -> CLEAR -> RUN -> SNAP -> STREAM -> IDLE.
//  - IDLE: start=1 latches run_cycles into timer; next state is CLEAR.
//  - CLEAR: lasts 1 cycle.
//    - Next state is RUN if timer != 0.
//    - Next state is SNAP if timer == 0 (zero-length run).
//  - RUN: timer decrements each cycle. The cycle with timer==1 is the last
//    RUN cycle, so RUN lasts exactly run_cycles cycles.
//  - SNAP: lasts 1 cycle. snapshot <= phase on the edge leaving SNAP.
//    Word index is cleared.
//  - STREAM:
//    - out_valid=1; out_data = snapshot[idx*WORD +: WORD], zero-padded.
//    - out_last = (idx == NWORDS-1).
//    - On valid&ready: idx++. On the last-word transfer: go to IDLE and
//      raise done in the first IDLE cycle.
//  - sample_rstn is registered from the next-state decode.
//    - It is 1 only while state is RUN or SNAP, 0 otherwise.
//    - The sampler is therefore held at its cutoff preset while idle/CLEAR,
//      and counters are frozen-free during the run.
//  - Handshake rules:
//    - While out_valid & !out_ready: out_data, out_last and idx hold stable.
//    - out_valid never drops without a transfer, except on rst.
//    - Phase changes during STREAM do not alter out_data (snapshot only).
//  - start while busy is ignored; it is neither queued nor latched.
//    run_cycles changes after latch are ignored.
//  - done and start in the same cycle: start is accepted (state is IDLE).
//  - Timer is 32-bit unsigned; run_cycles = 32'hFFFFFFFF is legal and
//    gives no wrap.
//  - rst mid-operation (any state): immediate return to the reset values
//    above; a partial stream is abandoned and no done is produced.
// STRUCTURE
//  - Shared defines.vh gets the FSM state encodings:
//    PR_IDLE, PR_CLEAR, PR_RUN, PR_SNAP, PR_STREAM (3-bit).
//  - NWORDS and the index width $clog2(NWORDS) are module localparams
//    (index width minimum 1).
//  - One sub-module, phase_word_mux #(N,WORD): combinational select of the
//    padded word by idx. The padded vector is NWORDS*WORD bits with zero
//    fill above N.
// TESTING
//  1. N=3, WORD=32, run_cycles=5, start pulse, out_ready=1, phase held 3'b101.
//     -> sample_rstn low 1 cycle after start and high for 6 cycles (RUN 5 + SNAP).
//     -> One word 32'h5 with out_last=1; done 1 cycle later.
//  2. N=40, WORD=32, phase=40'hA5_DEADBEEF, out_ready low 3 cycles then high.
//     -> Word0 32'hDEADBEEF held stable while stalled, out_last=0.
//     -> Word1 32'h000000A5 with out_last=1; done after word1.
//  3. run_cycles=0.
//     -> CLEAR goes directly to SNAP; sample_rstn high exactly 1 cycle.
//     -> Snapshot reflects phase in that cycle.
//  4. start pulsed again during RUN and during STREAM.
//     -> Ignored: timer unchanged, single stream, single done pulse.
//  5. rst asserted while word0 is stalled in STREAM (N=40).
//     -> out_valid=0, busy=0, sample_rstn=0 asynchronously; no done.
//     -> Next start runs normally.
//  6. phase toggled every cycle during STREAM with out_ready=0 for 4 cycles.
//     -> out_data stays equal to the SNAP-cycle value.

Source files
------------

// File: rtl/phase_readout_pkg.sv
// ============================================================================
// Module : phase_readout_pkg
// Brief  : Shared FSM state encoding and sizing helper for phase_readout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package phase_readout_pkg;

  typedef enum logic [2:0] {
    PR_IDLE   = 3'd0,
    PR_CLEAR  = 3'd1,
    PR_RUN    = 3'd2,
    PR_SNAP   = 3'd3,
    PR_STREAM = 3'd4
  } pr_state_e;

  // Word index width; never narrower than one bit, even for a single word.
  function automatic int idx_width(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/phase_readout_if.sv
// ============================================================================
// Module : phase_readout_if
// Brief  : Valid/ready word stream from the readout unit to the host.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface phase_readout_if #(
  parameter int WORD = 32
);
  logic [WORD-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/phase_word_mux.sv
// ============================================================================
// Module : phase_word_mux
// Brief  : Selects one WORD-bit slice of the zero-padded phase snapshot.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module phase_word_mux
  import phase_readout_pkg::*;
#(
  parameter  int N      = 3,
  parameter  int WORD   = 32,
  localparam int NWORDS = (N + WORD - 1) / WORD,
  localparam int IDXW   = idx_width(NWORDS)
) (
  input  logic [N-1:0]    vec,
  input  logic [IDXW-1:0] idx,
  output logic [WORD-1:0] word
);

  localparam int PADW = NWORDS * WORD;

  logic [PADW-1:0] padded;
  logic [WORD-1:0] words [NWORDS];

  generate
    if (PADW > N) begin : g_pad
      assign padded = {{(PADW - N){1'b0}}, vec};
    end else begin : g_nopad
      assign padded = vec;
    end

    for (genvar w = 0; w < NWORDS; w++) begin : g_word
      assign words[w] = padded[w*WORD +: WORD];
    end
  endgenerate

  always_comb begin
    word = '0;
    if (32'(idx) < NWORDS) word = words[idx];
  end

endmodule

`default_nettype wire

// File: rtl/phase_readout.sv
// ============================================================================
// Module : phase_readout
// Brief  : Run controller for the phase sampler plus snapshot word unloader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module phase_readout
  import phase_readout_pkg::*;
#(
  parameter int N    = 3,
  parameter int WORD = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          run_cycles,
  input  logic [N-1:0]         phase,
  output logic                 sample_rstn,
  output logic                 busy,
  output logic                 done,
  phase_readout_if.master      out
);

  localparam int              NWORDS   = (N + WORD - 1) / WORD;
  localparam int              IDXW     = idx_width(NWORDS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  pr_state_e       state;
  pr_state_e       state_nx;
  logic [31:0]     timer;
  logic [N-1:0]    snapshot;
  logic [IDXW-1:0] idx;
  logic [WORD-1:0] word;
  logic            xfer;
  logic            last_xfer;

  assign xfer      = (state == PR_STREAM) && out.out_ready;
  assign last_xfer = xfer && (idx == LAST_IDX);

  always_comb begin
    state_nx = state;
    unique case (state)
      PR_IDLE:   if (start) state_nx = PR_CLEAR;
      PR_CLEAR:  state_nx = (timer != 32'd0) ? PR_RUN : PR_SNAP;
      PR_RUN:    if (timer == 32'd1) state_nx = PR_SNAP;
      PR_SNAP:   state_nx = PR_STREAM;
      PR_STREAM: if (last_xfer) state_nx = PR_IDLE;
      default:   state_nx = PR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PR_IDLE;
      sample_rstn <= 1'b0;
      done        <= 1'b0;
      timer       <= '0;
      snapshot    <= '0;
      idx         <= '0;
    end else begin
      state <= state_nx;
      // Sampler runs free only while integrating or being captured.
      sample_rstn <= (state_nx == PR_RUN) || (state_nx == PR_SNAP);
      done        <= last_xfer;

      if (state == PR_IDLE && start) begin
        timer <= run_cycles;
      end else if (state == PR_RUN) begin
        timer <= timer - 32'd1;
      end

      if (state == PR_SNAP) begin
        snapshot <= phase;
        idx      <= '0;
      end else if (xfer) begin
        idx <= idx + IDXW'(1);
      end
    end
  end

  phase_word_mux #(
    .N    (N),
    .WORD (WORD)
  ) u_word_mux (
    .vec  (snapshot),
    .idx  (idx),
    .word (word)
  );

  assign busy          = (state != PR_IDLE);
  assign out.out_valid = (state == PR_STREAM);
  assign out.out_data  = out.out_valid ? word : '0;
  assign out.out_last  = out.out_valid && (idx == LAST_IDX);

endmodule

`default_nettype wire

// File: tb/tb_phase_readout.sv
// ============================================================================
// Module : tb_phase_readout
// Brief  : Randomized self-checking bench for phase_readout (N=40 and N=3).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_phase_readout;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] run_cycles = '0;
  logic [39:0] phase = '0;
  logic        sample_rstn, busy, done;

  logic        start3 = 1'b0;
  logic [31:0] run_cycles3 = '0;
  logic [2:0]  phase3 = '0;
  logic        sample_rstn3, busy3, done3;

  int checks = 0;
  int errors = 0;

  phase_readout_if #(.WORD(32)) bus  ();
  phase_readout_if #(.WORD(32)) bus3 ();

  phase_readout #(.N(40), .WORD(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .run_cycles  (run_cycles),
    .phase       (phase),
    .sample_rstn (sample_rstn),
    .busy        (busy),
    .done        (done),
    .out         (bus.master)
  );

  phase_readout #(.N(3), .WORD(32)) dut3 (
    .clk         (clk),
    .rst         (rst),
    .start       (start3),
    .run_cycles  (run_cycles3),
    .phase       (phase3),
    .sample_rstn (sample_rstn3),
    .busy        (busy3),
    .done        (done3),
    .out         (bus3.master)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [39:0] rand40();
    return {8'($urandom), 32'($urandom)};
  endfunction

  // Reference: word w of the snapshot is bits [32w+31:32w] with zero fill.
  function automatic logic [31:0] exp_word(input logic [39:0] s, input int w);
    return 32'(64'(s) >> (32 * w));
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"},  busy, 1'b0);
    check_eq({tag, "_valid"}, bus.out_valid, 1'b0);
    check_eq({tag, "_rstn"},  sample_rstn, 1'b0);
    check_eq({tag, "_done"},  done, 1'b0);
  endtask

  // One run on the N=40 unit, entered and left at a negedge with the DUT idle.
  task automatic run_one(input logic [31:0] r, input bit abort, input int stall,
                         input bit fix, input logic [39:0] fix_ph);
    logic [39:0] snap;
    int w;
    int guard;
    snap  = '0;
    start = 1'b1;
    run_cycles = r;
    phase = fix ? fix_ph : rand40();
    @(negedge clk);
    start = 1'b0;
    check_eq("clear_busy", busy, 1'b1);
    check_eq("clear_rstn", sample_rstn, 1'b0);
    check_eq("clear_valid", bus.out_valid, 1'b0);
    run_cycles = $urandom;
    phase = fix ? fix_ph : rand40();
    if (r == 0) snap = phase;
    for (int c = 1; c <= int'(r) + 1; c++) begin
      @(negedge clk);
      check_eq("run_rstn", sample_rstn, 1'b1);
      check_eq("run_valid", bus.out_valid, 1'b0);
      check_eq("run_busy", busy, 1'b1);
      check_eq("run_done", done, 1'b0);
      start = (c <= int'(r)) && ($urandom_range(3) == 0);
      phase = fix ? fix_ph : rand40();
      if (c == int'(r) + 1) snap = phase;
    end
    w = 0;
    guard = 0;
    while (w < 2) begin
      @(negedge clk);
      check_eq("st_valid", bus.out_valid, 1'b1);
      check_eq("st_data", bus.out_data, exp_word(snap, w));
      check_eq("st_last", bus.out_last, (w == 1));
      check_eq("st_busy", busy, 1'b1);
      check_eq("st_rstn", sample_rstn, 1'b0);
      check_eq("st_done", done, 1'b0);
      phase = fix ? ~phase : rand40();
      start = $urandom_range(1);
      if (abort && w == 0 && guard == 2) begin
        #2 rst = 1'b1;
        #1;
        check_eq("arst_valid", bus.out_valid, 1'b0);
        check_eq("arst_busy", busy, 1'b0);
        check_eq("arst_rstn", sample_rstn, 1'b0);
        start = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("post_abort");
        return;
      end
      if (guard < stall)     bus.out_ready = 1'b0;
      else if (guard > 40)   bus.out_ready = 1'b1;
      else                   bus.out_ready = 1'($urandom_range(1));
      guard++;
      if (bus.out_ready) w++;
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    start = 1'b0;
    check_eq("done_pulse", done, 1'b1);
    check_eq("done_busy", busy, 1'b0);
    check_eq("done_valid", bus.out_valid, 1'b0);
    check_eq("done_last", bus.out_last, 1'b0);
    check_eq("done_rstn", sample_rstn, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.out_ready  = 1'b0;
    bus3.out_ready = 1'b0;
    @(negedge clk);
    check_eq("rst_state40", {busy, sample_rstn, done, bus.out_valid, bus.out_last}, 5'b0);
    check_eq("rst_data40", bus.out_data, 32'h0);
    check_eq("rst_state3", {busy3, sample_rstn3, done3, bus3.out_valid, bus3.out_last}, 5'b0);
    rst = 1'b0;
    @(negedge clk);

    // N=3 single-word run: 5 integration cycles, phase 3'b101.
    start3 = 1'b1;
    run_cycles3 = 32'd5;
    phase3 = 3'b101;
    bus3.out_ready = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    check_eq("n3_clear_rstn", sample_rstn3, 1'b0);
    check_eq("n3_clear_busy", busy3, 1'b1);
    repeat (6) begin
      @(negedge clk);
      check_eq("n3_run_rstn", sample_rstn3, 1'b1);
      check_eq("n3_run_valid", bus3.out_valid, 1'b0);
    end
    @(negedge clk);
    check_eq("n3_valid", bus3.out_valid, 1'b1);
    check_eq("n3_data", bus3.out_data, 32'h5);
    check_eq("n3_last", bus3.out_last, 1'b1);
    check_eq("n3_rstn", sample_rstn3, 1'b0);
    @(negedge clk);
    check_eq("n3_done", done3, 1'b1);
    check_eq("n3_idle", {busy3, bus3.out_valid}, 2'b00);
    @(negedge clk);
    check_eq("n3_done_once", done3, 1'b0);

    run_one(32'd5, 1'b0, 0, 1'b1, 40'h5);
    run_one(32'd3, 1'b0, 3, 1'b1, 40'hA5_DEADBEEF);
    run_one(32'd0, 1'b0, 0, 1'b0, 40'h0);
    run_one(32'd2, 1'b1, 4, 1'b1, 40'hA5_DEADBEEF);
    run_one(32'd1, 1'b0, 4, 1'b1, 40'h3C_12345678);

    for (int i = 0; i < 20; i++) begin
      int gap;
      gap = $urandom_range(2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check_idle("gap");
      end
      run_one(32'($urandom_range(9)), 1'b0, int'($urandom_range(3)), 1'b0, 40'h0);
    end

    // Maximum run length must not wrap into an early snapshot.
    @(negedge clk);
    start = 1'b1;
    run_cycles = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    check_eq("max_clear_rstn", sample_rstn, 1'b0);
    repeat (30) begin
      @(negedge clk);
      check_eq("max_run_rstn", sample_rstn, 1'b1);
      check_eq("max_run_valid", bus.out_valid, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("max_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
